// File: rtl/spi_rx_buffer_if.sv
// rtl/spi_rx_buffer_if.sv - SPI receive buffer bus: slave word/done in, FWFT valid/ready out, overflow status
//
// Signals:
//   rx_data   word from the SPI slave, stable while rx_done is high
//   rx_done   frame-complete level from the slave (sclk domain)
//   out_data  head-of-FIFO word
//   out_valid FIFO holds at least one word
//   out_ready consumer accepts out_data this cycle
//   level     number of stored words, 0..DEPTH
//   overflow  sticky flag: a frame was dropped because the FIFO was full
//   clr_ovf   clears overflow
// Modports: master drives the inputs of the buffer, slave is the buffer itself.
interface spi_rx_buffer_if #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 4
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] rx_data;
    logic              rx_done;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [AW:0]       level;
    logic              overflow;
    logic              clr_ovf;

    modport master (
        output rx_data, rx_done, out_ready, clr_ovf,
        input  out_data, out_valid, level, overflow
    );

    modport slave (
        input  rx_data, rx_done, out_ready, clr_ovf,
        output out_data, out_valid, level, overflow
    );
endinterface

// File: rtl/spi_rx_buffer.sv
// rtl/spi_rx_buffer.sv - re-times SPI rx_done into clk, captures one word per frame into a FWFT FIFO
//
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset; discards buffered words
//   bus  spi_rx_buffer_if.slave (rx_data/rx_done in, out_data/out_valid/out_ready,
//        level, overflow, clr_ovf)
module spi_rx_buffer #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst,
    spi_rx_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // rx_done synchroniser and edge detector
    logic r_s1, r_s2, r_s3;
    // r_fill counts edges since reset until r_s2 holds a real post-reset sample;
    // r_armed is set only once rx_done has been seen low after that, so a done
    // level already high across reset cannot masquerade as a new frame.
    logic [1:0] r_fill;
    logic       r_armed;
    logic       w_push_evt;

    // Registered push strobe and captured word (written one edge later)
    logic              r_push;
    logic [DATA_W-1:0] r_cap;

    // FIFO state
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              r_overflow;

    logic w_full;
    logic w_valid;
    logic w_pop;
    logic w_wr;
    logic w_drop;

    assign w_push_evt = r_s2 & ~r_s3 & r_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_fill  <= 2'd0;
            r_armed <= 1'b0;
            r_push  <= 1'b0;
            r_cap   <= '0;
        end else begin
            r_s1   <= bus.rx_done;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_push <= w_push_evt;
            if (r_fill != 2'd2) begin
                r_fill <= r_fill + 2'd1;
            end
            if (r_fill == 2'd2 && !r_s2) begin
                r_armed <= 1'b1;
            end
            // rx_done is still high here, so rx_data is stable without its own synchroniser
            if (w_push_evt) begin
                r_cap <= bus.rx_data;
            end
        end
    end

    assign w_full  = (r_level == LVL_FULL);
    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid & bus.out_ready;
    // A full FIFO can still accept a word when the head leaves in the same cycle
    assign w_wr    = r_push & (~w_full | w_pop);
    assign w_drop  = r_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_wr && !w_pop) begin
                r_level <= r_level + LVL_ONE;
            end else if (w_pop && !w_wr) begin
                r_level <= r_level - LVL_ONE;
            end
            // A drop in the same cycle as clr_ovf keeps the flag set
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_cap;
        end
    end

    assign bus.out_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.out_valid = w_valid;
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_spi_rx_buffer.sv
// tb/tb_spi_rx_buffer.sv - self-checking bench for spi_rx_buffer
module tb_spi_rx_buffer;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst;

    spi_rx_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    spi_rx_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    typedef enum int {OP_FRAME, OP_POP, OP_CLR, OP_IDLE} op_t;

    typedef struct {
        op_t               op;
        logic [DATA_W-1:0] data;
        int                exp_level;
        logic              exp_valid;
        logic              exp_ovf;
        logic [DATA_W-1:0] exp_head;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int lvl, input logic vld, input logic ovf);
        chk({tag, " level"}, int'(bus.level), lvl);
        chk({tag, " out_valid"}, int'(bus.out_valid), int'(vld));
        chk({tag, " overflow"}, int'(bus.overflow), int'(ovf));
    endtask

    // rx_done high for 'hold' cycles then low for 4 cycles
    task automatic send_frame(input logic [DATA_W-1:0] d, input int hold);
        bus.rx_data = d;
        bus.rx_done = 1'b1;
        repeat (hold) tick();
        bus.rx_done = 1'b0;
        repeat (4) tick();
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [DATA_W-1:0] d);
        chk({tag, " head"}, int'(bus.out_data), int'(d));
        pop_one();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.rx_data   = '0;
        bus.rx_done   = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        rst = 1'b1;

        vecs[0]  = '{OP_FRAME, 12'h001, 1, 1'b1, 1'b0, 12'h001};
        vecs[1]  = '{OP_FRAME, 12'h002, 2, 1'b1, 1'b0, 12'h001};
        vecs[2]  = '{OP_FRAME, 12'h003, 3, 1'b1, 1'b0, 12'h001};
        vecs[3]  = '{OP_FRAME, 12'h004, 4, 1'b1, 1'b0, 12'h001};
        vecs[4]  = '{OP_FRAME, 12'h005, 4, 1'b1, 1'b1, 12'h001};
        vecs[5]  = '{OP_POP,   12'h000, 3, 1'b1, 1'b1, 12'h002};
        vecs[6]  = '{OP_POP,   12'h000, 2, 1'b1, 1'b1, 12'h003};
        vecs[7]  = '{OP_POP,   12'h000, 1, 1'b1, 1'b1, 12'h004};
        vecs[8]  = '{OP_POP,   12'h000, 0, 1'b0, 1'b1, 12'h000};
        vecs[9]  = '{OP_POP,   12'h000, 0, 1'b0, 1'b1, 12'h000};
        vecs[10] = '{OP_CLR,   12'h000, 0, 1'b0, 1'b0, 12'h000};

        repeat (3) tick();
        chk_state("reset", 0, 1'b0, 1'b0);
        chk("reset out_data", int'(bus.out_data), 0);
        rst = 1'b0;
        repeat (4) tick();

        // Single frame with exact latency
        bus.rx_data = 12'hA5C;
        bus.rx_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("lat edge N+%0d valid", i), int'(bus.out_valid), 0);
        end
        tick();
        chk("lat edge N+3 valid", int'(bus.out_valid), 1);
        chk("single head", int'(bus.out_data), 'hA5C);
        chk("single level", int'(bus.level), 1);
        repeat (18) tick();
        bus.rx_done = 1'b0;
        repeat (4) tick();
        chk("single level after hold", int'(bus.level), 1);
        pop_one();
        chk_state("single popped", 0, 1'b0, 1'b0);

        // Long done yields one push
        send_frame(12'h123, 100);
        chk("long level", int'(bus.level), 1);
        chk("long head", int'(bus.out_data), 'h123);
        pop_one();
        chk("long drained", int'(bus.level), 0);

        // Table: fill, overflow, drain, empty pop, clear
        for (int i = 0; i < 11; i++) begin
            case (vecs[i].op)
                OP_FRAME: send_frame(vecs[i].data, 6);
                OP_POP:   pop_one();
                OP_CLR: begin
                    bus.clr_ovf = 1'b1;
                    tick();
                    bus.clr_ovf = 1'b0;
                end
                default:  tick();
            endcase
            chk_state($sformatf("vec%0d", i), vecs[i].exp_level, vecs[i].exp_valid, vecs[i].exp_ovf);
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d head", i), int'(bus.out_data), int'(vecs[i].exp_head));
        end

        // Full with pop in the push cycle; pointers wrap here
        for (int i = 0; i < 4; i++) send_frame(12'h010 + DATA_W'(i), 6);
        chk("full2 level", int'(bus.level), 4);
        bus.rx_data = 12'h014;
        bus.rx_done = 1'b1;
        repeat (3) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk_state("push+pop full", 4, 1'b1, 1'b0);
        repeat (3) tick();
        bus.rx_done = 1'b0;
        repeat (4) tick();
        pop_expect("wrap0", 12'h011);
        pop_expect("wrap1", 12'h012);
        pop_expect("wrap2", 12'h013);
        pop_expect("wrap3", 12'h014);
        chk("wrap drained", int'(bus.level), 0);

        // clr_ovf coinciding with a dropped push: set wins
        for (int i = 0; i < 4; i++) send_frame(12'h020 + DATA_W'(i), 6);
        bus.rx_data = 12'h0FF;
        bus.rx_done = 1'b1;
        repeat (3) tick();
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk_state("clr vs drop", 4, 1'b1, 1'b1);
        repeat (3) tick();
        bus.rx_done = 1'b0;
        repeat (4) tick();
        pop_expect("ovf2 a", 12'h020);
        pop_expect("ovf2 b", 12'h021);
        chk_state("pre-reset", 2, 1'b1, 1'b1);

        // Reset mid-operation with rx_done high
        bus.rx_data = 12'h0AA;
        bus.rx_done = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_state("mid reset", 0, 1'b0, 1'b0);
        repeat (10) tick();
        chk("in-flight done ignored", int'(bus.level), 0);
        bus.rx_done = 1'b0;
        repeat (4) tick();
        send_frame(12'h03C, 6);
        chk("rearm level", int'(bus.level), 1);
        chk("rearm head", int'(bus.out_data), 'h03C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
